// File: rtl/hdmi_pkg.sv
// Shared HDMI/DVI definitions: TMDS word type, control tokens, TERC4 symbol table
// and small helpers used by the TMDS encoder.
package hdmi_pkg;

  typedef logic [9:0] tmds_word_t;

  // Control tokens, written MSB first; bit 0 goes on the wire first.
  localparam tmds_word_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_word_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_word_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_word_t CTRL_TOKEN_11 = 10'b1010101011;

  localparam tmds_word_t TERC4_TABLE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic tmds_word_t ctrl_token(input logic [1:0] c);
    tmds_word_t w;
    case (c)
      2'b00:   w = CTRL_TOKEN_00;
      2'b01:   w = CTRL_TOKEN_01;
      2'b10:   w = CTRL_TOKEN_10;
      default: w = CTRL_TOKEN_11;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tmds_terc4_lut.sv
// Combinational TERC4 lookup: 4-bit aux nibble to 10-bit HDMI data-island symbol.
module tmds_terc4_lut
  import hdmi_pkg::*;
(
  input  logic [3:0] terc4_nibble,
  output logic [9:0] terc4_symbol
);

  assign terc4_symbol = TERC4_TABLE[terc4_nibble];

endmodule

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder: transition minimisation, DC balancing and
// control tokens; define TMDS_TERC4_EN to add the aux_en/aux_data TERC4 path.
module tmds_encoder #(
  parameter int LATENCY_PAD = 0
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [7:0] vid_data,
  input  logic       vid_de,
  input  logic [1:0] ctrl,
`ifdef TMDS_TERC4_EN
  input  logic       aux_en,
  input  logic [3:0] aux_data,
`endif
  output logic [9:0] tmds
);

  import hdmi_pkg::*;

  // Stage 1: transition-minimised q_m.
  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m_d;

  always_comb begin
    n1_d     = ones8(vid_data);
    use_xnor = (n1_d > 4'd4) || (n1_d == 4'd4 && !vid_data[0]);
    q_m_d    = '0;
    q_m_d[0] = vid_data[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ vid_data[i]) : (q_m_d[i-1] ^ vid_data[i]);
    q_m_d[8] = ~use_xnor;
  end

  logic [8:0] s1_q_m;
  logic       s1_de;
  logic [1:0] s1_ctrl;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      s1_de   <= 1'b0;
      s1_ctrl <= 2'b00;
    end else begin
      s1_de   <= vid_de;
      s1_ctrl <= ctrl;
    end
  end

  // NOTE: q_m needs no reset; it is only consumed while s1_de, which is reset.
  always_ff @(posedge clk_pix) s1_q_m <= q_m_d;

`ifdef TMDS_TERC4_EN
  logic       s1_aux_en;
  logic [3:0] s1_aux_data;
  logic [9:0] aux_symbol;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      s1_aux_en   <= 1'b0;
      s1_aux_data <= 4'h0;
    end else begin
      s1_aux_en   <= aux_en;
      s1_aux_data <= aux_data;
    end
  end

  tmds_terc4_lut u_terc4 (
    .terc4_nibble(s1_aux_data),
    .terc4_symbol(aux_symbol)
  );
`endif

  // Stage 2: DC balancing. diff is n1-n0 of q_m[7:0]; all disparity math stays in
  // 5-bit two's complement because cnt never leaves -10..+10.
  logic signed [4:0] cnt, cnt_d, diff, delta;
  logic [3:0]        n1;
  logic              qm8;
  tmds_word_t        word_d, enc_q;

  assign n1   = ones8(s1_q_m[7:0]);
  assign qm8  = s1_q_m[8];
  assign diff = {n1, 1'b0} - 5'sd8;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word_d = ctrl_token(s1_ctrl);
    delta  = '0;
    cnt_d  = '0;
`ifdef TMDS_TERC4_EN
    if (s1_aux_en) word_d = aux_symbol;
`endif
    if (s1_de) begin
      if (cnt == 5'sd0 || diff == 5'sd0) begin
        word_d = {~qm8, qm8, qm8 ? s1_q_m[7:0] : ~s1_q_m[7:0]};
        delta  = qm8 ? diff : -diff;
      end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
        word_d = {1'b1, qm8, ~s1_q_m[7:0]};
        delta  = (qm8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
        word_d = {1'b0, qm8, s1_q_m[7:0]};
        delta  = diff - (qm8 ? 5'sd0 : 5'sd2);
      end
      cnt_d = cnt + delta;
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      enc_q <= CTRL_TOKEN_00;
      cnt   <= '0;
    end else begin
      enc_q <= word_d;
      cnt   <= cnt_d;
    end
  end

  // Optional pad stages, reset to the blanking token like the rest of the pipe.
  generate
    if (LATENCY_PAD == 0) begin : g_no_pad
      assign tmds = enc_q;
    end else begin : g_pad
      tmds_word_t pad_q [LATENCY_PAD];

      always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LATENCY_PAD; i++) pad_q[i] <= CTRL_TOKEN_00;
        end else begin
          pad_q[0] <= enc_q;
          for (int i = 1; i < LATENCY_PAD; i++) pad_q[i] <= pad_q[i-1];
        end
      end

      assign tmds = pad_q[LATENCY_PAD-1];
    end
  endgenerate

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: LATENCY_PAD=0 and LATENCY_PAD=2 instances
// share stimulus and are scored against an arithmetic model of the TMDS rules.
module tb_tmds_encoder;

  logic       clk_pix = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] vid_data = 8'h00;
  logic       vid_de   = 1'b0;
  logic [1:0] ctrl     = 2'b00;
`ifdef TMDS_TERC4_EN
  logic       aux_en   = 1'b0;
  logic [3:0] aux_data = 4'h0;
`endif
  logic [9:0] tmds0, tmds2;

  always #5 clk_pix = ~clk_pix;

  tmds_encoder #(.LATENCY_PAD(0)) dut0 (
    .clk_pix(clk_pix), .rst(rst), .vid_data(vid_data), .vid_de(vid_de), .ctrl(ctrl),
`ifdef TMDS_TERC4_EN
    .aux_en(aux_en), .aux_data(aux_data),
`endif
    .tmds(tmds0)
  );

  tmds_encoder #(.LATENCY_PAD(2)) dut2 (
    .clk_pix(clk_pix), .rst(rst), .vid_data(vid_data), .vid_de(vid_de), .ctrl(ctrl),
`ifdef TMDS_TERC4_EN
    .aux_en(aux_en), .aux_data(aux_data),
`endif
    .tmds(tmds2)
  );

  logic [9:0] tok   [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Per sampled input: expected word, model disparity after it, and whether it was video.
  logic [9:0] exp_q [$];
  int         cnt_q [$];
  bit         de_q  [$];
  int         m_cnt;
  int         run_disp;
  int         errors = 0;
  int         checks = 0;

  task automatic model_push(input logic [7:0] d, input logic de, input logic [1:0] c,
                            input logic ax, input logic [3:0] ad, input logic in_rst);
    logic [9:0] w;
    logic [7:0] qm;
    bit         inv_chain, q8;
    int         ones_in, bal;
    if (in_rst) begin
      w = tok[0];
      m_cnt = 0;
    end else if (!de) begin
      w = ax ? terc4[ad] : tok[c];
      m_cnt = 0;
    end else begin
      ones_in   = $countones(d);
      inv_chain = (ones_in > 4) || (ones_in == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ inv_chain;
      q8  = !inv_chain;
      bal = 2 * $countones(qm) - 8;
      if (m_cnt == 0 || bal == 0) begin
        w = {~q8, q8, q8 ? qm : ~qm};
        m_cnt += q8 ? bal : -bal;
      end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
        w = {1'b1, q8, ~qm};
        m_cnt += 2 * int'(q8) - bal;
      end else begin
        w = {1'b0, q8, qm};
        m_cnt += bal - 2 * int'(!q8);
      end
    end
    exp_q.push_back(w);
    cnt_q.push_back(m_cnt);
    de_q.push_back(de && !in_rst);
  endtask

  task automatic step(input logic [7:0] d, input logic de, input logic [1:0] c,
                      input logic ax, input logic [3:0] ad);
    int n;
    int dut_cnt;
    vid_data = d; vid_de = de; ctrl = c;
`ifdef TMDS_TERC4_EN
    aux_en = ax; aux_data = ad;
`endif
    @(posedge clk_pix);
    model_push(d, de, c, ax, ad, rst);
    #1;
    n = exp_q.size();
    dut_cnt = int'(dut0.cnt);
    checks++;
    if (tmds0 !== exp_q[n-2]) begin
      errors++; $display("FAIL word_pad0 t=%0t got=%b exp=%b", $time, tmds0, exp_q[n-2]);
    end
    checks++;
    if (tmds2 !== exp_q[n-4]) begin
      errors++; $display("FAIL word_pad2 t=%0t got=%b exp=%b", $time, tmds2, exp_q[n-4]);
    end
    checks++;
    if (dut_cnt != cnt_q[n-2]) begin
      errors++; $display("FAIL cnt t=%0t got=%0d exp=%0d", $time, dut_cnt, cnt_q[n-2]);
    end
    checks++;
    if (dut_cnt > 10 || dut_cnt < -10) begin
      errors++; $display("FAIL cnt_range t=%0t got=%0d exp=-10..10", $time, dut_cnt);
    end
    if (de_q[n-2]) run_disp += 2 * $countones(tmds0) - 10;
    else           run_disp = 0;
    checks++;
    if (run_disp > 10 || run_disp < -10) begin
      errors++; $display("FAIL run_disparity t=%0t got=%0d exp=-10..10", $time, run_disp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom), 1'($urandom), 2'($urandom), 1'b0, 4'h0);
      checks++;
      if (tmds0 !== 10'b1101010100 || tmds2 !== 10'b1101010100) begin
        errors++; $display("FAIL reset_hold got=%b/%b exp=1101010100", tmds0, tmds2);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom), 1'b0, 2'b01, 1'b0, 4'h0);
      if (i == 1) begin
        checks++;
        if (tmds0 !== 10'b0010101011) begin
          errors++; $display("FAIL reset_release got=%b exp=0010101011", tmds0);
        end
      end
    end
    checks++;
    if (tmds2 !== 10'b0010101011) begin
      errors++; $display("FAIL reset_release_pad2 got=%b exp=0010101011", tmds2);
    end
  endtask

  task automatic test_ctrl_tokens();
    for (int c = 0; c < 4; c++) begin
      step(8'($urandom), 1'b0, 2'(c), 1'b0, 4'h0);
      step(8'($urandom), 1'b0, 2'(c), 1'b0, 4'h0);
      checks++;
      if (tmds0 !== tok[c]) begin
        errors++; $display("FAIL ctrl_token c=%0d got=%b exp=%b", c, tmds0, tok[c]);
      end
    end
  endtask

  task automatic test_zero_pixels();
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b1, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b1, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds0 !== 10'b0100000000 || int'(dut0.cnt) != -8) begin
      errors++; $display("FAIL zero_first got=%b cnt=%0d exp=0100000000 cnt=-8", tmds0, int'(dut0.cnt));
    end
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds0 !== 10'b1111111111 || int'(dut0.cnt) != 2) begin
      errors++; $display("FAIL zero_second got=%b cnt=%0d exp=1111111111 cnt=2", tmds0, int'(dut0.cnt));
    end
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds2 !== 10'b0100000000) begin
      errors++; $display("FAIL zero_first_pad2 got=%b exp=0100000000", tmds2);
    end
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds2 !== 10'b1111111111) begin
      errors++; $display("FAIL zero_second_pad2 got=%b exp=1111111111", tmds2);
    end
  endtask

  task automatic test_de_drop();
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b1, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds0 !== 10'b1101010100) begin
      errors++; $display("FAIL de_drop_token got=%b exp=1101010100", tmds0);
    end
    step(8'h00, 1'b1, 2'b00, 1'b0, 4'h0);
    checks++;
    if (tmds0 !== 10'b0100000000 || int'(dut0.cnt) != -8) begin
      errors++; $display("FAIL de_drop_restart got=%b cnt=%0d exp=0100000000 cnt=-8", tmds0, int'(dut0.cnt));
    end
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
  endtask

  task automatic apply_async_reset(input string tag);
    int n;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (tmds0 !== 10'b1101010100 || tmds2 !== 10'b1101010100 || int'(dut0.cnt) != 0) begin
      errors++;
      $display("FAIL %s got=%b/%b cnt=%0d exp=1101010100 cnt=0", tag, tmds0, tmds2, int'(dut0.cnt));
    end
    n = exp_q.size();
    for (int i = n - 4; i < n; i++) begin
      exp_q[i] = tok[0];
      cnt_q[i] = 0;
      de_q[i]  = 1'b0;
    end
    m_cnt = 0;
    run_disp = 0;
    step(8'($urandom), 1'b1, 2'b00, 1'b0, 4'h0);
    step(8'($urandom), 1'b1, 2'b00, 1'b0, 4'h0);
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(8'($urandom), 1'b1, 2'b00, 1'b0, 4'h0);
    apply_async_reset("async_reset");
    for (int i = 0; i < 8; i++) step(8'($urandom), 1'b1, 2'b10, 1'b0, 4'h0);
  endtask

  task automatic test_random();
    int active = 0;
    logic [7:0] d;
    logic       ax;
    while (active < 10000) begin
      int run = $urandom_range(1, 40);
      if ($urandom_range(0, 4) == 0) run = 1;
      for (int i = 0; i < run; i++) begin
        case ($urandom_range(0, 7))
          0:       d = 8'h00;
          1:       d = 8'hFF;
          2:       d = 8'h0F;
          default: d = 8'($urandom);
        endcase
        ax = 1'b0;
`ifdef TMDS_TERC4_EN
        ax = 1'($urandom);
`endif
        step(d, 1'b1, 2'($urandom), ax, 4'($urandom));
        active++;
      end
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        ax = 1'b0;
`ifdef TMDS_TERC4_EN
        ax = 1'($urandom);
`endif
        step(8'($urandom), 1'b0, 2'($urandom), ax, 4'($urandom));
      end
    end
  endtask

`ifdef TMDS_TERC4_EN
  task automatic test_terc4();
    for (int i = 0; i <= 16; i++) begin
      step(8'($urandom), 1'b0, 2'($urandom), 1'b1, 4'(i));
      if (i >= 1) begin
        checks++;
        if (tmds0 !== terc4[i-1]) begin
          errors++; $display("FAIL terc4 nib=%0d got=%b exp=%b", i - 1, tmds0, terc4[i-1]);
        end
      end
    end
    for (int i = 0; i < 6; i++) step(8'($urandom), 1'b0, 2'b00, 1'b1, 4'(i));
    apply_async_reset("terc4_async_reset");
    for (int i = 0; i < 4; i++) step(8'($urandom), 1'b0, 2'b00, 1'b1, 4'(i));
  endtask
`endif

  initial begin
    m_cnt = 0;
    run_disp = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(10'b1101010100);
      cnt_q.push_back(0);
      de_q.push_back(1'b0);
    end
    test_reset();
    test_ctrl_tokens();
    test_zero_pixels();
    test_de_drop();
    test_async_reset();
`ifdef TMDS_TERC4_EN
    test_terc4();
`endif
    test_random();
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    step(8'h00, 1'b0, 2'b00, 1'b0, 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL expose parameter LATENCY_PAD, default 0, meaning extra output register stages (legal 0..2) for aligning channels with external sync delays.
REQ-002 SHALL have port clk_pix, input, 1 bit: pixel clock, the only clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port vid_data, input, 8 bits: pixel component.
REQ-005 SHALL have port vid_de, input, 1 bit: video data enable.
REQ-006 SHALL have port ctrl, input, 2 bits: control bits {c1,c0}, used when vid_de=0.
REQ-007 SHALL have port tmds, output, 10 bits: encoded TMDS word, bit 0 transmitted first.

Function
REQ-008 SHALL register all inputs through a 2-stage pipeline, plus LATENCY_PAD stages; total latency is 2+LATENCY_PAD clk_pix cycles, with vid_de and ctrl delayed identically.
REQ-009 Stage 1 SHALL compute N1 = ones(vid_data) and select XNOR when N1>4, or when N1==4 and vid_data[0]==0; otherwise XOR.
REQ-010 Stage 1 SHALL form q_m[0]=d[0] and q_m[i]=q_m[i-1] XOR/XNOR d[i] for i=1..7; q_m[8]=1 for XOR and 0 for XNOR.
REQ-011 Stage 2 SHALL hold running disparity cnt as a 5-bit signed register, with n1/n0 = ones/zeros of q_m[7:0].
REQ-012 If cnt==0 or n1==n0: tmds={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (n1-n0) : (n0-n1).
REQ-013 If (cnt>0 and n1>n0) or (cnt<0 and n0>n1): tmds={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (n0-n1).
REQ-014 Otherwise: tmds={0, q_m[8], q_m[7:0]}; cnt += (n1-n0) - 2*(~q_m[8]).
REQ-015 When delayed vid_de=0, the block SHALL output the control token (MSB first) 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011, and SHALL clear cnt to 0 in the same cycle.
REQ-016 The first active pixel after any blanking SHALL be encoded with cnt==0; a single-cycle vid_de pulse SHALL be encoded correctly.
REQ-017 cnt SHALL remain within -10..+10 for any input sequence; no saturation logic is required.

Reset
REQ-018 While rst is high: tmds=1101010100, cnt=0, and all pipeline and pad stages hold vid_de=0, ctrl=00.
REQ-019 Assertion of rst mid-line SHALL take effect immediately (asynchronously); after deassertion, the first valid output appears 2+LATENCY_PAD cycles after the first sampled input.

Configuration
REQ-020 With macro TMDS_TERC4_EN defined, the block SHALL add input aux_en (1 bit) and input aux_data (4 bits).
REQ-021 When delayed aux_en=1 and vid_de=0, the output SHALL be the HDMI TERC4 symbol for aux_data, MSB first: 0:1010011100, 1:1001100011, 2:1011100100, 3:1011100010, 4:0101110001, 5:0100011110, 6:0110001110, 7:0100111100, 8:1011001100, 9:0100111001, A:0110011100, B:1011000110, C:1010001110, D:1001110001, E:0101100011, F:1011000011.
REQ-022 TERC4 periods SHALL clear cnt as in REQ-015; if vid_de=1 and aux_en=1 together, vid_de wins.
REQ-023 Without TMDS_TERC4_EN, the aux ports and TERC4 logic SHALL be absent, and behaviour SHALL be exactly REQ-008..019.

Structure
REQ-024 Shared package hdmi_pkg SHALL hold the tmds_word_t (10-bit) typedef, the four control-token constants, and the TERC4 table constant.
REQ-025 The optional sub-module tmds_terc4_lut (4-bit in, 10-bit out, combinational) SHALL be instantiated only under TMDS_TERC4_EN; the disparity stage SHALL stay in tmds_encoder.

Verification
REQ-026 Hold rst=1 -> tmds=1101010100 every cycle; deassert with vid_de=0, ctrl=01 -> tmds=0010101011 two cycles later (LATENCY_PAD=0).
REQ-027 Blanking, then vid_de=1 with vid_data=0x00 for two cycles -> outputs 0100000000 then 1111111111, with cnt=-8 then +2.
REQ-028 vid_de dropped for 1 cycle mid-line, then 0x00 resumes -> control token, then 0100000000 again (cnt restarted at 0).
REQ-029 10k random pixels with random blanking against a behavioural model -> bit-exact match, |cnt|<=10, and cumulative (ones-zeros) of each active run within ±10.
REQ-030 With TMDS_TERC4_EN: aux_en=1, aux_data=0..F sequenced -> 16 table words per REQ-021; assert rst mid-sequence -> immediate 1101010100.
REQ-031 Run REQ-027 with LATENCY_PAD=2 -> identical words, delivered 4 cycles after input.
